// File: rtl/seg7_display_ctrl_if.sv
// rtl/seg7_display_ctrl_if.sv - value/control and display-drive bundle for seg7_display_ctrl
//  master: drives the value to show and the control strobes, and observes status and display drive
//  slave : the display controller
//  bin_in/neg_in/load/blank_lz : magnitude, sign, 1-cycle capture strobe, leading-zero blanking
//  busy/overflow               : conversion status, last committed value did not fit
//  segments/digits             : active-low {dp,g..a} and one-hot active-low digit enables
interface seg7_display_ctrl_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_W      = 16
);
    logic [BIN_W-1:0]      bin_in;
    logic                  neg_in;
    logic                  load;
    logic                  blank_lz;
    logic                  busy;
    logic                  overflow;
    logic [7:0]            segments;
    logic [NUM_DIGITS-1:0] digits;

    modport master (
        output bin_in, neg_in, load, blank_lz,
        input  busy, overflow, segments, digits
    );

    modport slave (
        input  bin_in, neg_in, load, blank_lz,
        output busy, overflow, segments, digits
    );
endinterface

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - N-digit multiplexed common-anode 7-segment controller with BCD conversion
//  clk_50Mhz : system clock
//  rst       : synchronous active-low reset
//  bus       : seg7_display_ctrl_if slave (bin_in, neg_in, load, blank_lz in; busy, overflow,
//              segments, digits out)
//  A load in IDLE captures the value; a sequential double-dabble runs BIN_W steps, then all
//  display registers commit on one edge. Scanning runs independently off a free prescaler.
module seg7_display_ctrl #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_W       = 16,
    parameter int REFRESH_DIV = 13
) (
    input  logic                 clk_50Mhz,
    input  logic                 rst,
    seg7_display_ctrl_if.slave   bus
);

    // Decimal digits needed for 2**BIN_W-1; equals ceil(BIN_W*log10(2)). BIN_W must stay below 64.
    function automatic int num_dec_digits(input int w);
        longint v;
        int     d;
        v = (longint'(1) <<< w) - 1;
        d = 0;
        for (int i = 0; i < 20; i++) begin
            if (v > 0) begin
                d++;
                v = v / 10;
            end
        end
        return d;
    endfunction

    localparam int BCD_DIGITS = num_dec_digits(BIN_W);
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int PAD_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int CNT_W      = $clog2(BIN_W + 1);
    localparam int IDX_W      = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } state_t;

    state_t                     state_q, state_d;
    logic [BIN_W-1:0]           bin_q, bin_d;
    logic [BCD_W-1:0]           bcd_q, bcd_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       neg_q, neg_d;

    logic [NUM_DIGITS-1:0][3:0] disp_q, disp_d;
    logic                       sign_q, sign_d;
    logic                       ovf_q, ovf_d;

    logic [REFRESH_DIV-1:0]     presc_q;
    logic [IDX_W-1:0]           scan_q;
    logic [7:0]                 seg_q;
    logic [NUM_DIGITS-1:0]      dig_q;

    logic [BCD_W-1:0]           bcd_adj;
    logic [4*PAD_DIGITS-1:0]    bcd_pad;
    logic [NUM_DIGITS-1:0][3:0] commit_digits;
    logic                       conv_ovf;
    logic                       bcd_nz;
    logic [IDX_W-1:0]           msnz_idx;
    logic [6:0]                 seg_nxt;
    logic [NUM_DIGITS-1:0]      dig_nxt;

    // Double-dabble pre-shift correction: any BCD nibble >= 5 gets +3 so the shift carries into the next decade.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Zero-extend the BCD result so the capacity check and digit copy can index either width safely.
    assign bcd_pad = (4*PAD_DIGITS)'(bcd_q);

    always_comb begin
        conv_ovf      = 1'b0;
        bcd_nz        = 1'b0;
        commit_digits = '0;
        for (int i = 0; i < PAD_DIGITS; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) begin
                bcd_nz = 1'b1;
                // A negative value gives up the leftmost digit to the minus sign.
                if (i >= (neg_q ? NUM_DIGITS - 1 : NUM_DIGITS)) begin
                    conv_ovf = 1'b1;
                end
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            commit_digits[i] = bcd_pad[4*i +: 4];
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        disp_d  = disp_q;
        sign_d  = sign_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.load) begin
                    bin_d   = bus.bin_in;
                    neg_d   = bus.neg_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d  = commit_digits;
                ovf_d   = conv_ovf;
                // Negative zero is shown as plain "0".
                sign_d  = neg_q & bcd_nz;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Highest nonzero committed digit; stays 0 for a zero value so the units digit is never blanked.
    always_comb begin
        msnz_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (disp_q[i] != 4'd0) begin
                msnz_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        dig_nxt = ~(NUM_DIGITS'(1) << scan_q);
        if (ovf_q) begin
            seg_nxt = SEG_DASH;
        end else if (sign_q && (scan_q == IDX_W'(NUM_DIGITS - 1))) begin
            seg_nxt = SEG_DASH;
        end else if (bus.blank_lz && (scan_q > msnz_idx)) begin
            seg_nxt = SEG_BLANK;
        end else begin
            seg_nxt = decode_digit(disp_q[scan_q]);
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            disp_q  <= '0;
            sign_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            disp_q  <= disp_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_50Mhz) begin
        if (!rst) begin
            presc_q <= '0;
            scan_q  <= '0;
            seg_q   <= 8'hFF;
            dig_q   <= '1;
        end else begin
            presc_q <= presc_q + 1'b1;
            if (&presc_q) begin
                scan_q <= (scan_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
            end
            seg_q <= {1'b1, seg_nxt};
            dig_q <= dig_nxt;
        end
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.overflow = ovf_q;
    assign bus.segments = seg_q;
    assign bus.digits   = dig_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - self-checking bench for seg7_display_ctrl (4- and 6-digit instances)
module tb_seg7_display_ctrl;

    logic clk_50Mhz = 1'b0;
    logic rst       = 1'b0;
    always #5 clk_50Mhz = ~clk_50Mhz;

    seg7_display_ctrl_if #(.NUM_DIGITS(4), .BIN_W(16)) if4 ();
    seg7_display_ctrl_if #(.NUM_DIGITS(6), .BIN_W(16)) if6 ();

    seg7_display_ctrl #(.NUM_DIGITS(4), .BIN_W(16), .REFRESH_DIV(3)) dut4 (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .bus(if4.slave));
    seg7_display_ctrl #(.NUM_DIGITS(6), .BIN_W(16), .REFRESH_DIV(3)) dut6 (
        .clk_50Mhz(clk_50Mhz), .rst(rst), .bus(if6.slave));

    int     n_cmp = 0;
    int     n_err = 0;
    int     edge_cnt = 0;
    longint m_val = 0;
    bit     m_neg = 1'b0;
    bit     blz   = 1'b0;

    // Clock edges since reset release; the scan slot advances every 8 of them.
    always @(posedge clk_50Mhz) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint pow10(input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [6:0] glyph(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic bit model_ovf(input int n, input longint v, input bit neg);
        return v >= pow10(neg ? n - 1 : n);
    endfunction

    function automatic logic [6:0] model_seg(input int n, input longint v, input bit neg,
                                             input bit b, input int idx);
        int     nd;
        longint t;
        if (model_ovf(n, v, neg))           return 7'b0111111;
        if (neg && v != 0 && idx == n - 1)  return 7'b0111111;
        nd = 1;
        t  = v / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        if (b && idx >= nd)                 return 7'b1111111;
        return glyph(int'((v / pow10(idx)) % 10));
    endfunction

    task automatic drive(input longint v, input bit neg, input bit ld);
        if4.bin_in = 16'(v); if6.bin_in = 16'(v);
        if4.neg_in = neg;    if6.neg_in = neg;
        if4.load   = ld;     if6.load   = ld;
    endtask

    task automatic set_blz(input bit b);
        blz = b;
        if4.blank_lz = b;
        if6.blank_lz = b;
    endtask

    task automatic check_cycle();
        int idx4, idx6;
        logic [3:0] d4;
        logic [5:0] d6;
        idx4 = ((edge_cnt - 1) / 8) % 4;
        idx6 = ((edge_cnt - 1) / 8) % 6;
        d4 = ~(4'b0001 << idx4);
        d6 = ~(6'b000001 << idx6);
        check_eq("digits4", if4.digits, d4);
        check_eq("segs4", if4.segments, {1'b1, model_seg(4, m_val, m_neg, blz, idx4)});
        check_eq("digits6", if6.digits, d6);
        check_eq("segs6", if6.segments, {1'b1, model_seg(6, m_val, m_neg, blz, idx6)});
    endtask

    task automatic check_frame(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_50Mhz);
            check_cycle();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_busy4"}, if4.busy, 1'b0);
        check_eq({tag, "_busy6"}, if6.busy, 1'b0);
        check_eq({tag, "_ovf4"}, if4.overflow, 1'b0);
        check_eq({tag, "_ovf6"}, if6.overflow, 1'b0);
        check_eq({tag, "_segs4"}, if4.segments, 8'hFF);
        check_eq({tag, "_segs6"}, if6.segments, 8'hFF);
        check_eq({tag, "_digits4"}, if4.digits, 4'hF);
        check_eq({tag, "_digits6"}, if6.digits, 6'h3F);
    endtask

    // inject: 0 = plain load, 1 = extra load (value 8) during conversion, 2 = reset during conversion
    task automatic do_load(input longint v, input bit neg, input int inject);
        int  cnt;
        bit  done;
        bit  o4, o6;
        o4 = model_ovf(4, m_val, m_neg);
        o6 = model_ovf(6, m_val, m_neg);
        @(negedge clk_50Mhz);
        drive(v, neg, 1'b1);
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk_50Mhz);
            drive(v, neg, 1'b0);
            if (!if4.busy) begin
                done = 1'b1;
            end else begin
                cnt++;
                check_eq("busy6", if6.busy, 1'b1);
                check_eq("ovf4_hold", if4.overflow, o4);
                check_eq("ovf6_hold", if6.overflow, o6);
                check_cycle();
                if (inject == 1 && cnt == 5) begin
                    drive(8, 1'b0, 1'b1);
                end
                if (inject == 2 && cnt == 5) begin
                    rst = 1'b0;
                    @(negedge clk_50Mhz);
                    check_reset_state("midconv_rst");
                    rst   = 1'b1;
                    m_val = 0;
                    m_neg = 1'b0;
                    return;
                end
            end
        end
        check_eq("busy_len", cnt, 17);
        check_eq("busy6_end", if6.busy, 1'b0);
        // Registered drive still reflects the previous commit on this cycle.
        check_cycle();
        m_val = v;
        m_neg = neg;
        check_eq("ovf4", if4.overflow, model_ovf(4, m_val, m_neg));
        check_eq("ovf6", if6.overflow, model_ovf(6, m_val, m_neg));
    endtask

    initial begin
        longint v;
        bit     ng;
        drive(0, 1'b0, 1'b0);
        set_blz(1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk_50Mhz);
        check_reset_state("reset");
        rst = 1'b1;

        check_frame(48);
        set_blz(1'b1);
        check_frame(48);

        set_blz(1'b0);
        do_load(1234, 1'b0, 0);  check_frame(48);
        set_blz(1'b1);
        do_load(42, 1'b1, 0);    check_frame(48);
        set_blz(1'b0);           check_frame(48);
        do_load(999, 1'b1, 0);   check_frame(32);
        do_load(1000, 1'b1, 0);  check_frame(32);
        do_load(10000, 1'b0, 0); check_frame(32);
        do_load(5, 1'b0, 0);     check_frame(32);
        do_load(7, 1'b0, 1);     check_frame(48);
        do_load(9, 1'b0, 2);     check_frame(48);
        set_blz(1'b1);
        do_load(65535, 1'b0, 0); check_frame(48);
        do_load(0, 1'b1, 0);     check_frame(48);
        do_load(9999, 1'b0, 0);  check_frame(32);

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 4))
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 999);
                2:       v = $urandom_range(990, 1010);
                3:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 65535);
            endcase
            ng = 1'($urandom_range(0, 1));
            set_blz(1'($urandom_range(0, 1)));
            do_load(v, ng, 0);
            check_frame(24);
            set_blz(~blz);
            check_frame(24);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
